instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 158 +++++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one request in flight, 2-entry {ins, PC} buffer toward decode,
// with redirect support that drains an in-flight response before refetching.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        jmp_flag,
   input  logic [31:0] jmp_addr,
   output logic [31:0] ins,
   output logic [31:0] PC,
   output logic        ins_valid,
   input  logic        ins_ready
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [31:0]      r_fetchPc;
   logic [31:0]      r_reqPc;
   logic             r_outstanding;
   logic             r_discard;
   logic             r_run;
   logic [31:0]      r_fifoIns [BUF_DEPTH];
   logic [31:0]      r_fifoPc  [BUF_DEPTH];
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W-1:0] r_wrPtr;
   logic [CNT_W-1:0] r_count;

   logic             w_req;
   logic             w_accept;
   logic             w_rsp;
   logic             w_keep;
   logic             w_pop;
   logic             w_slotFree;
   logic             w_unusedJmpLsb;

   // Buffered entries plus the in-flight one must never exceed the buffer depth.
   assign w_slotFree = ({1'b0, r_count} + {{CNT_W{1'b0}}, r_outstanding}) < {1'b0, DEPTH_V};
   assign w_accept   = w_req && imem_ready;
   assign w_rsp      = imem_rvalid && r_outstanding;
   assign w_keep     = w_rsp && !r_discard && !jmp_flag;
   assign w_pop      = (r_count != '0) && ins_ready;

   assign w_unusedJmpLsb = ^jmp_addr[1:0];

   assign imem_req  = w_req;
   assign imem_addr = r_fetchPc;
   assign ins       = r_fifoIns[r_rdPtr];
   assign PC        = r_fifoPc[r_rdPtr];
   assign ins_valid = (r_count != '0);

   always_comb begin
      w_nextState = r_state;
      w_req       = 1'b0;
      case (r_state)
         S_REQ: begin
            w_req = r_run && !jmp_flag && w_slotFree;
            if (w_req && imem_ready) begin
               w_nextState = S_WAIT;
            end
         end
         // A response arriving together with a redirect is dropped but still ends the wait.
         S_WAIT: begin
            if (w_rsp) begin
               w_nextState = S_REQ;
            end else if (jmp_flag) begin
               w_nextState = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_rsp) begin
               w_nextState = S_REQ;
            end
         end
         default: w_nextState = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_REQ;
         r_fetchPc     <= RESET_PC;
         r_reqPc       <= '0;
         r_outstanding <= 1'b0;
         r_discard     <= 1'b0;
         r_run         <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_run   <= 1'b1;
         if (jmp_flag) begin
            r_fetchPc <= {jmp_addr[31:2], 2'b00};
         end else if (w_accept) begin
            r_fetchPc <= r_fetchPc + 32'd4;
         end
         if (w_accept) begin
            r_reqPc <= r_fetchPc;
         end
         if (w_accept) begin
            r_outstanding <= 1'b1;
         end else if (w_rsp) begin
            r_outstanding <= 1'b0;
         end
         if (w_rsp) begin
            r_discard <= 1'b0;
         end else if (jmp_flag && r_outstanding) begin
            r_discard <= 1'b1;
         end
      end
   end

   // A redirect flushes the buffer; a pop in that same cycle is simply absorbed by the flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_fifoIns[i] <= '0;
            r_fifoPc[i]  <= '0;
         end
      end else if (jmp_flag) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_keep) begin
            r_fifoIns[r_wrPtr] <= imem_rdata;
            r_fifoPc[r_wrPtr]  <= r_reqPc;
            r_wrPtr            <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_keep, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle directed vector table on a default instance, then a
// free-running zero-wait sequence on a second instance started near the top of the address space.
module tb_instr_fetch;

   logic        clk;
   logic        rstN;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        jmpFlag;
   logic [31:0] jmpAddr;
   logic [31:0] insOut;
   logic [31:0] pcOut;
   logic        insValid;
   logic        insReady;

   logic        wRstN;
   logic        wReq;
   logic [31:0] wAddr;
   logic        wReady;
   logic        wRvalid;
   logic [31:0] wRdata;
   logic [31:0] wIns;
   logic [31:0] wPc;
   logic        wValid;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] DB = 32'hA000_0000;

   typedef struct {
      logic        rstN;
      logic        imemReady;
      logic        imemRvalid;
      logic [31:0] imemRdata;
      logic        jmpFlag;
      logic [31:0] jmpAddr;
      logic        insReady;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic        chkData;
      logic [31:0] expIns;
      logic [31:0] expPc;
   } vec_t;

   vec_t vecs[$];

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rstN),
      .imem_req    (imemReq),
      .imem_addr   (imemAddr),
      .imem_ready  (imemReady),
      .imem_rvalid (imemRvalid),
      .imem_rdata  (imemRdata),
      .jmp_flag    (jmpFlag),
      .jmp_addr    (jmpAddr),
      .ins         (insOut),
      .PC          (pcOut),
      .ins_valid   (insValid),
      .ins_ready   (insReady)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
      .clk         (clk),
      .rst_n       (wRstN),
      .imem_req    (wReq),
      .imem_addr   (wAddr),
      .imem_ready  (wReady),
      .imem_rvalid (wRvalid),
      .imem_rdata  (wRdata),
      .jmp_flag    (1'b0),
      .jmp_addr    (32'h0),
      .ins         (wIns),
      .PC          (wPc),
      .ins_valid   (wValid),
      .ins_ready   (1'b1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic addRow(input int rst, input int rdy, input int rv, input logic [31:0] rdata,
                         input int jmp, input logic [31:0] jaddr, input int insRdy,
                         input int eReq, input logic [31:0] eAddr, input int eValid,
                         input int chk, input logic [31:0] eIns, input logic [31:0] ePc);
      vec_t v;
      v.rstN       = (rst != 0);
      v.imemReady  = (rdy != 0);
      v.imemRvalid = (rv != 0);
      v.imemRdata  = rdata;
      v.jmpFlag    = (jmp != 0);
      v.jmpAddr    = jaddr;
      v.insReady   = (insRdy != 0);
      v.expReq     = (eReq != 0);
      v.expAddr    = eAddr;
      v.expValid   = (eValid != 0);
      v.chkData    = (chk != 0);
      v.expIns     = eIns;
      v.expPc      = ePc;
      vecs.push_back(v);
   endtask

   task automatic checkVal(input int idx, input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL row %0d %s: got %h expected %h", idx, name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rstN       = v.rstN;
      imemReady  = v.imemReady;
      imemRvalid = v.imemRvalid;
      imemRdata  = v.imemRdata;
      jmpFlag    = v.jmpFlag;
      jmpAddr    = v.jmpAddr;
      insReady   = v.insReady;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      checkVal(idx, "imem_req", {31'b0, imemReq}, {31'b0, v.expReq});
      checkVal(idx, "imem_addr", imemAddr, v.expAddr);
      checkVal(idx, "ins_valid", {31'b0, insValid}, {31'b0, v.expValid});
      if (v.chkData) begin
         checkVal(idx, "ins", insOut, v.expIns);
         checkVal(idx, "PC", pcOut, v.expPc);
      end
   endtask

   logic [31:0] expWrap [3];
   logic [31:0] gotPc   [3];
   logic [31:0] gotIns  [3];
   int          got;
   logic        pending;
   logic [31:0] pendAddr;

   initial begin
      rstN = 1'b0; imemReady = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
      jmpFlag = 1'b0; jmpAddr = '0; insReady = 1'b0;
      wRstN = 1'b0; wReady = 1'b0; wRvalid = 1'b0; wRdata = '0;

      //     rst rdy rv rdata          jmp jaddr  insR | req addr   iv chk ins            pc
      // reset and first request after release
      addRow(0, 0, 0, 0,              0, 0,     0,     0, 'h0,   0, 1, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     0, 'h0,   0, 1, 0,             0);
      // zero-wait memory, decode always ready
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 0, 1, DB + 'h0,       0, 0,     1,     0, 'h4,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h4,   1, 1, DB + 'h0,      'h0);
      addRow(1, 0, 1, DB + 'h4,       0, 0,     1,     0, 'h8,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h8,   1, 1, DB + 'h4,      'h4);
      addRow(1, 0, 1, DB + 'h8,       0, 0,     1,     0, 'hC,   0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'hC,   1, 1, DB + 'h8,      'h8);
      // reset again
      addRow(0, 0, 0, 0,              0, 0,     0,     1, 'hC,   0, 0, 0,             0);
      addRow(0, 0, 0, 0,              0, 0,     0,     0, 'h0,   0, 1, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     0,     0, 'h0,   0, 0, 0,             0);
      // memory stalls three cycles; address must hold
      addRow(1, 0, 0, 0,              0, 0,     0,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     0,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     0,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     0,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     0,     0, 'h4,   0, 0, 0,             0);
      // decode stalled: buffer fills to two and requests stop
      addRow(1, 1, 1, DB + 'h0,       0, 0,     0,     0, 'h4,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     0,     1, 'h4,   1, 1, DB + 'h0,      'h0);
      addRow(1, 1, 1, DB + 'h4,       0, 0,     0,     0, 'h8,   1, 1, DB + 'h0,      'h0);
      addRow(1, 1, 0, 0,              0, 0,     0,     0, 'h8,   1, 1, DB + 'h0,      'h0);
      addRow(1, 1, 0, 0,              0, 0,     0,     0, 'h8,   1, 1, DB + 'h0,      'h0);
      addRow(1, 1, 0, 0,              0, 0,     1,     0, 'h8,   1, 1, DB + 'h0,      'h0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'h8,   1, 1, DB + 'h4,      'h4);
      addRow(1, 0, 0, 0,              0, 0,     0,     1, 'h8,   0, 0, 0,             0);
      // refill, then redirect to an unaligned target while idle and full
      addRow(1, 1, 0, 0,              0, 0,     0,     1, 'h8,   0, 0, 0,             0);
      addRow(1, 0, 1, DB + 'h8,       0, 0,     0,     0, 'hC,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     0,     1, 'hC,   1, 1, DB + 'h8,      'h8);
      addRow(1, 0, 1, DB + 'hC,       0, 0,     0,     0, 'h10,  1, 1, DB + 'h8,      'h8);
      addRow(1, 0, 0, 0,              0, 0,     0,     0, 'h10,  1, 1, DB + 'h8,      'h8);
      addRow(1, 1, 0, 0,              1, 'h203, 0,     0, 'h10,  1, 1, DB + 'h8,      'h8);
      addRow(1, 0, 0, 0,              0, 0,     0,     1, 'h200, 0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     0,     1, 'h200, 0, 0, 0,             0);
      addRow(1, 0, 1, DB + 'h200,     0, 0,     0,     0, 'h204, 0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'h204, 1, 1, DB + 'h200,    'h200);
      // redirect with a request in flight: its response must be dropped
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h204, 0, 0, 0,             0);
      addRow(1, 0, 0, 0,              1, 'h100, 1,     0, 'h208, 0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     1,     0, 'h100, 0, 0, 0,             0);
      addRow(1, 1, 1, DB + 'h204,     0, 0,     1,     0, 'h100, 0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h100, 0, 0, 0,             0);
      addRow(1, 0, 1, DB + 'h100,     0, 0,     1,     0, 'h104, 0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'h104, 1, 1, DB + 'h100,    'h100);
      // reset while waiting, then a stale response
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h104, 0, 0, 0,             0);
      addRow(0, 0, 0, 0,              0, 0,     1,     0, 'h108, 0, 0, 0,             0);
      addRow(1, 0, 1, 'hDEAD_BEEF,    0, 0,     1,     0, 'h0,   0, 1, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h0,   0, 0, 0,             0);
      addRow(1, 0, 1, 'h1111_0000,    0, 0,     1,     0, 'h4,   0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'h4,   1, 1, 'h1111_0000,   'h0);
      // redirect and response in the same cycle: response dropped, refetch at once
      addRow(1, 1, 0, 0,              0, 0,     1,     1, 'h4,   0, 0, 0,             0);
      addRow(1, 0, 1, 'h2222_0000,    1, 'h40,  1,     0, 'h8,   0, 0, 0,             0);
      addRow(1, 0, 0, 0,              0, 0,     1,     1, 'h40,  0, 0, 0,             0);

      repeat (2) @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput(i, vecs[i]);
      end

      // Second instance: zero-wait memory answering the cycle after each acceptance.
      expWrap[0] = 32'hFFFF_FFF8;
      expWrap[1] = 32'hFFFF_FFFC;
      expWrap[2] = 32'h0000_0000;
      got      = 0;
      pending  = 1'b0;
      pendAddr = '0;
      @(negedge clk);
      wRstN = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         @(negedge clk);
         wReady  = 1'b1;
         wRvalid = pending;
         wRdata  = 32'h5A00_0000 ^ pendAddr;
         #1;
         if (wValid) begin
            gotPc[got]  = wPc;
            gotIns[got] = wIns;
            got++;
         end
         pending = wReq && wReady;
         if (pending) begin
            pendAddr = wAddr;
         end
      end
      checkVal(100, "wrap delivery count", got, 3);
      for (int i = 0; i < got; i++) begin
         checkVal(101 + i, "wrap PC", gotPc[i], expWrap[i]);
         checkVal(101 + i, "wrap ins", gotIns[i], 32'h5A00_0000 ^ expWrap[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
